// File: rtl/dma_fsm_mq.sv
// rtl/dma_fsm_mq.sv - multi-descriptor DMA control FSM with in-order descriptor FIFO
//
// Queues up to DESC_DEPTH descriptors. On dma_go_i it retires them in order,
// handshaking each with the read and write streamers. It then waits for
// outstanding AXI transactions to drain and reports done. The first error
// seen while active is captured.
//
// Optional feature macro: DMA_FSM_ABORT_EN (adds abort_i / aborted_o).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   dma_go_i                  start / hold-done level
//   desc_valid_i/ready_o      descriptor push handshake (ready = FIFO not full)
//   desc_*_i                  pushed descriptor fields
//   cur_*_o                   head descriptor fields (0 when empty)
//   stream_rd/wr_valid_o      per-streamer request for the head descriptor
//   stream_rd/wr_done_i       per-streamer completion of the head descriptor
//   axi_pend_txn_i            AXI I/F still has outstanding transactions
//   axi/rd/wr_err_*           error reports (AXI > rd > wr priority)
//   dma_active_o/dma_done_o   RUN|DRAIN / DONE status
//   dma_error_o               any error input valid while active (combinational)
//   err_valid/src/addr_o      first captured error (src 0=rd, 1=wr)
//   clear_dma_o               one-cycle pulse after leaving DONE
//   desc_done_cnt_o           descriptors retired since the last start
//   queue_level_o             FIFO occupancy
//   abort_i/aborted_o         [DMA_FSM_ABORT_EN] abort request / abort status
module dma_fsm_mq #(
    parameter int DESC_DEPTH = 4,
    parameter int BYTES_W    = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dma_go_i,
    input  logic                        desc_valid_i,
    output logic                        desc_ready_o,
    input  logic [BYTES_W-1:0]          desc_num_bytes_i,
    input  logic [ADDR_W-1:0]           desc_src_addr_i,
    input  logic [ADDR_W-1:0]           desc_dst_addr_i,
    output logic [BYTES_W-1:0]          cur_num_bytes_o,
    output logic [ADDR_W-1:0]           cur_src_addr_o,
    output logic [ADDR_W-1:0]           cur_dst_addr_o,
    output logic                        stream_rd_valid_o,
    input  logic                        stream_rd_done_i,
    output logic                        stream_wr_valid_o,
    input  logic                        stream_wr_done_i,
    input  logic                        axi_pend_txn_i,
    input  logic                        axi_err_valid_i,
    input  logic                        axi_err_src_i,
    input  logic [ADDR_W-1:0]           axi_err_addr_i,
    input  logic                        rd_err_valid_i,
    input  logic [ADDR_W-1:0]           rd_err_addr_i,
    input  logic                        wr_err_valid_i,
    input  logic [ADDR_W-1:0]           wr_err_addr_i,
    output logic                        dma_active_o,
    output logic                        dma_done_o,
    output logic                        dma_error_o,
    output logic                        err_valid_o,
    output logic                        err_src_o,
    output logic [ADDR_W-1:0]           err_addr_o,
    output logic                        clear_dma_o,
    output logic [CNT_W-1:0]            desc_done_cnt_o,
`ifdef DMA_FSM_ABORT_EN
    input  logic                        abort_i,
    output logic                        aborted_o,
`endif
    output logic [$clog2(DESC_DEPTH):0] queue_level_o
);

    localparam int PTR_W = $clog2(DESC_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DESC_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state;

    logic [BYTES_W-1:0] mem_bytes [DESC_DEPTH];
    logic [ADDR_W-1:0]  mem_src   [DESC_DEPTH];
    logic [ADDR_W-1:0]  mem_dst   [DESC_DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr, rd_ptr, level, level_next;
    logic           empty, full;
    logic           push, pop, retire, in_run, abort_run;
    logic           rd_done_ff, wr_done_ff;
    logic           err_take, err_src_n;
    logic [ADDR_W-1:0] err_addr_n;

    assign level  = wr_ptr - rd_ptr;
    assign empty  = (level == '0);
    assign full   = (level == LVL_FULL);
    assign in_run = (state == S_RUN);

`ifdef DMA_FSM_ABORT_EN
    assign abort_run = in_run && abort_i;
`else
    assign abort_run = 1'b0;
`endif

    assign cur_num_bytes_o = empty ? '0 : mem_bytes[rd_ptr[PTR_W-1:0]];
    assign cur_src_addr_o  = empty ? '0 : mem_src[rd_ptr[PTR_W-1:0]];
    assign cur_dst_addr_o  = empty ? '0 : mem_dst[rd_ptr[PTR_W-1:0]];

    assign desc_ready_o  = !full;
    assign queue_level_o = level;

    // Pushes are dropped in the abort cycle so the flush leaves the FIFO empty.
    assign push = desc_valid_i && !full && !abort_run;

    // Zero-length descriptors retire at once without asserting any valid.
    assign retire = in_run && !abort_run &&
                    ((cur_num_bytes_o == '0) ||
                     ((rd_done_ff || stream_rd_done_i) && (wr_done_ff || stream_wr_done_i)));
    assign pop = retire;

    assign level_next = level + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    // Valids drop in the retire cycle so the streamers never see the old head
    // requested twice; the next head appears one cycle later.
    assign stream_rd_valid_o = in_run && !abort_run && !retire &&
                               (cur_num_bytes_o != '0) && !rd_done_ff;
    assign stream_wr_valid_o = in_run && !abort_run && !retire &&
                               (cur_num_bytes_o != '0) && !wr_done_ff;

    assign dma_active_o = (state == S_RUN) || (state == S_DRAIN);
    assign dma_done_o   = (state == S_DONE);
    assign dma_error_o  = dma_active_o && (axi_err_valid_i || rd_err_valid_i || wr_err_valid_i);

    always_comb begin
        err_take   = 1'b0;
        err_src_n  = 1'b0;
        err_addr_n = '0;
        if (axi_err_valid_i) begin
            err_take   = 1'b1;
            err_src_n  = axi_err_src_i;
            err_addr_n = axi_err_addr_i;
        end else if (rd_err_valid_i) begin
            err_take   = 1'b1;
            err_src_n  = 1'b0;
            err_addr_n = rd_err_addr_i;
        end else if (wr_err_valid_i) begin
            err_take   = 1'b1;
            err_src_n  = 1'b1;
            err_addr_n = wr_err_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_bytes[wr_ptr[PTR_W-1:0]] <= desc_num_bytes_i;
            mem_src[wr_ptr[PTR_W-1:0]]   <= desc_src_addr_i;
            mem_dst[wr_ptr[PTR_W-1:0]]   <= desc_dst_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            rd_done_ff      <= 1'b0;
            wr_done_ff      <= 1'b0;
            err_valid_o     <= 1'b0;
            err_src_o       <= 1'b0;
            err_addr_o      <= '0;
            desc_done_cnt_o <= '0;
            clear_dma_o     <= 1'b0;
`ifdef DMA_FSM_ABORT_EN
            aborted_o       <= 1'b0;
`endif
        end else begin
            clear_dma_o <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

            // First error wins; the lock holds until the next start.
            if (dma_active_o && !err_valid_o && err_take) begin
                err_valid_o <= 1'b1;
                err_src_o   <= err_src_n;
                err_addr_o  <= err_addr_n;
            end

            case (state)
                S_IDLE: begin
                    if (dma_go_i) begin
                        if (!empty) begin
                            state           <= S_RUN;
                            err_valid_o     <= 1'b0;
                            err_src_o       <= 1'b0;
                            err_addr_o      <= '0;
                            desc_done_cnt_o <= '0;
`ifdef DMA_FSM_ABORT_EN
                            aborted_o       <= 1'b0;
`endif
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (abort_run) begin
                        rd_ptr     <= wr_ptr;
                        rd_done_ff <= 1'b0;
                        wr_done_ff <= 1'b0;
                        state      <= S_DRAIN;
`ifdef DMA_FSM_ABORT_EN
                        aborted_o  <= 1'b1;
`endif
                    end else if (retire) begin
                        desc_done_cnt_o <= desc_done_cnt_o + CNT_W'(1);
                        rd_done_ff      <= 1'b0;
                        wr_done_ff      <= 1'b0;
                        if (level_next == '0) state <= S_DRAIN;
                    end else begin
                        if (stream_rd_done_i) rd_done_ff <= 1'b1;
                        if (stream_wr_done_i) wr_done_ff <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!axi_pend_txn_i) state <= S_DONE;
                end
                default: begin
                    if (!dma_go_i) begin
                        state       <= S_IDLE;
                        clear_dma_o <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_fsm_mq.sv
// tb/tb_dma_fsm_mq.sv - self-checking bench for dma_fsm_mq against a queue-based reference model
module tb_dma_fsm_mq;

    localparam int DEPTH = 4;
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_go_i, desc_valid_i, desc_ready_o;
    logic [31:0] desc_num_bytes_i, desc_src_addr_i, desc_dst_addr_i;
    logic [31:0] cur_num_bytes_o, cur_src_addr_o, cur_dst_addr_o;
    logic        stream_rd_valid_o, stream_rd_done_i, stream_wr_valid_o, stream_wr_done_i;
    logic        axi_pend_txn_i, axi_err_valid_i, axi_err_src_i;
    logic [31:0] axi_err_addr_i;
    logic        rd_err_valid_i, wr_err_valid_i;
    logic [31:0] rd_err_addr_i, wr_err_addr_i;
    logic        dma_active_o, dma_done_o, dma_error_o, err_valid_o, err_src_o;
    logic [31:0] err_addr_o;
    logic        clear_dma_o;
    logic [15:0] desc_done_cnt_o;
    logic [2:0]  queue_level_o;
`ifdef DMA_FSM_ABORT_EN
    logic        abort_i, aborted_o;
`endif

    always #5 clk = ~clk;

    dma_fsm_mq #(.DESC_DEPTH(DEPTH), .BYTES_W(32), .ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dma_go_i(dma_go_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_num_bytes_i(desc_num_bytes_i), .desc_src_addr_i(desc_src_addr_i),
        .desc_dst_addr_i(desc_dst_addr_i),
        .cur_num_bytes_o(cur_num_bytes_o), .cur_src_addr_o(cur_src_addr_o),
        .cur_dst_addr_o(cur_dst_addr_o),
        .stream_rd_valid_o(stream_rd_valid_o), .stream_rd_done_i(stream_rd_done_i),
        .stream_wr_valid_o(stream_wr_valid_o), .stream_wr_done_i(stream_wr_done_i),
        .axi_pend_txn_i(axi_pend_txn_i),
        .axi_err_valid_i(axi_err_valid_i), .axi_err_src_i(axi_err_src_i),
        .axi_err_addr_i(axi_err_addr_i),
        .rd_err_valid_i(rd_err_valid_i), .rd_err_addr_i(rd_err_addr_i),
        .wr_err_valid_i(wr_err_valid_i), .wr_err_addr_i(wr_err_addr_i),
        .dma_active_o(dma_active_o), .dma_done_o(dma_done_o), .dma_error_o(dma_error_o),
        .err_valid_o(err_valid_o), .err_src_o(err_src_o), .err_addr_o(err_addr_o),
        .clear_dma_o(clear_dma_o), .desc_done_cnt_o(desc_done_cnt_o),
`ifdef DMA_FSM_ABORT_EN
        .abort_i(abort_i), .aborted_o(aborted_o),
`endif
        .queue_level_o(queue_level_o)
    );

    // Reference model: a descriptor queue plus a coarse run phase.
    typedef struct packed {
        logic [31:0] nb;
        logic [31:0] src;
        logic [31:0] dst;
    } desc_t;

    desc_t       mq[$];
    int          m_phase;
    bit          m_rdf, m_wrf, m_errv, m_errs, m_clr;
    logic [31:0] m_erra;
    int          m_cnt;
`ifdef DMA_FSM_ABORT_EN
    bit          m_abt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = PH_IDLE;
        m_rdf = 0; m_wrf = 0; m_errv = 0; m_errs = 0; m_erra = '0; m_clr = 0; m_cnt = 0;
`ifdef DMA_FSM_ABORT_EN
        m_abt = 0;
`endif
    endtask

    // One clock: compare every output at the falling edge, advance the model,
    // then return just after the rising edge so the caller can drive inputs.
    task automatic step();
        desc_t h, nd;
        bit run, act, abt, ret, push;
        @(negedge clk);
        h   = (mq.size() != 0) ? mq[0] : '0;
        run = (m_phase == PH_RUN);
        act = run || (m_phase == PH_DRAIN);
        abt = 0;
`ifdef DMA_FSM_ABORT_EN
        abt = run && abort_i;
        check_eq("aborted", aborted_o, m_abt);
`endif
        ret = run && !abt && ((h.nb == 0) ||
              ((m_rdf || stream_rd_done_i) && (m_wrf || stream_wr_done_i)));
        check_eq("desc_ready", desc_ready_o, mq.size() < DEPTH);
        check_eq("queue_level", queue_level_o, mq.size());
        check_eq("cur_num_bytes", cur_num_bytes_o, h.nb);
        check_eq("cur_src", cur_src_addr_o, h.src);
        check_eq("cur_dst", cur_dst_addr_o, h.dst);
        check_eq("rd_valid", stream_rd_valid_o, run && !abt && !ret && h.nb != 0 && !m_rdf);
        check_eq("wr_valid", stream_wr_valid_o, run && !abt && !ret && h.nb != 0 && !m_wrf);
        check_eq("active", dma_active_o, act);
        check_eq("done", dma_done_o, m_phase == PH_DONE);
        check_eq("dma_error", dma_error_o,
                 act && (axi_err_valid_i || rd_err_valid_i || wr_err_valid_i));
        check_eq("err_valid", err_valid_o, m_errv);
        check_eq("err_src", err_src_o, m_errs);
        check_eq("err_addr", err_addr_o, m_erra);
        check_eq("clear_dma", clear_dma_o, m_clr);
        check_eq("done_cnt", desc_done_cnt_o, m_cnt);

        if (rst) begin
            model_reset();
        end else begin
            push = desc_valid_i && (mq.size() < DEPTH) && !abt;
            if (act && !m_errv) begin
                if (axi_err_valid_i) begin
                    m_errv = 1; m_errs = axi_err_src_i; m_erra = axi_err_addr_i;
                end else if (rd_err_valid_i) begin
                    m_errv = 1; m_errs = 0; m_erra = rd_err_addr_i;
                end else if (wr_err_valid_i) begin
                    m_errv = 1; m_errs = 1; m_erra = wr_err_addr_i;
                end
            end
            m_clr = 0;
            case (m_phase)
                PH_IDLE: if (dma_go_i) begin
                    if (mq.size() != 0) begin
                        m_phase = PH_RUN;
                        m_errv = 0; m_errs = 0; m_erra = '0; m_cnt = 0;
`ifdef DMA_FSM_ABORT_EN
                        m_abt = 0;
`endif
                    end else begin
                        m_phase = PH_DONE;
                    end
                end
                PH_RUN: if (abt) begin
                    mq.delete();
                    m_rdf = 0; m_wrf = 0;
                    m_phase = PH_DRAIN;
`ifdef DMA_FSM_ABORT_EN
                    m_abt = 1;
`endif
                end else if (ret) begin
                    void'(mq.pop_front());
                    m_cnt = (m_cnt + 1) % 65536;
                    m_rdf = 0; m_wrf = 0;
                    if (mq.size() == 0 && !push) m_phase = PH_DRAIN;
                end else begin
                    if (stream_rd_done_i) m_rdf = 1;
                    if (stream_wr_done_i) m_wrf = 1;
                end
                PH_DRAIN: if (!axi_pend_txn_i) m_phase = PH_DONE;
                default: if (!dma_go_i) begin
                    m_phase = PH_IDLE;
                    m_clr = 1;
                end
            endcase
            if (push) begin
                nd.nb = desc_num_bytes_i; nd.src = desc_src_addr_i; nd.dst = desc_dst_addr_i;
                mq.push_back(nd);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic [31:0] nb, input logic [31:0] src, input logic [31:0] dst);
        desc_valid_i = 1'b1;
        desc_num_bytes_i = nb; desc_src_addr_i = src; desc_dst_addr_i = dst;
    endtask

    // Acknowledge every streamer request immediately until DONE or the budget expires.
    task automatic run_until_done(input string tag, input int budget, output int rd_pulses);
        bit finished = 0;
        rd_pulses = 0;
        for (int i = 0; i < budget && !finished; i++) begin
            stream_rd_done_i = 1'b0; stream_wr_done_i = 1'b0;
            #1;
            if (dma_done_o) begin
                finished = 1;
            end else begin
                if (stream_rd_valid_o) rd_pulses++;
                stream_rd_done_i = stream_rd_valid_o;
                stream_wr_done_i = stream_wr_valid_o;
                step();
            end
        end
        stream_rd_done_i = 1'b0; stream_wr_done_i = 1'b0;
        check_eq(tag, finished, 1);
    endtask

    task automatic drive_random();
        if ($urandom_range(0, 11) == 0) dma_go_i = !dma_go_i;
        desc_valid_i     = ($urandom_range(0, 1) == 1);
        desc_num_bytes_i = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
        desc_src_addr_i  = $urandom;
        desc_dst_addr_i  = $urandom;
        stream_rd_done_i = ($urandom_range(0, 2) == 0);
        stream_wr_done_i = ($urandom_range(0, 2) == 0);
        axi_pend_txn_i   = ($urandom_range(0, 1) == 1);
        axi_err_valid_i  = ($urandom_range(0, 24) == 0);
        axi_err_src_i    = ($urandom_range(0, 1) == 1);
        axi_err_addr_i   = $urandom;
        rd_err_valid_i   = ($urandom_range(0, 24) == 0);
        rd_err_addr_i    = $urandom;
        wr_err_valid_i   = ($urandom_range(0, 24) == 0);
        wr_err_addr_i    = $urandom;
        rst              = ($urandom_range(0, 399) == 0);
`ifdef DMA_FSM_ABORT_EN
        abort_i          = ($urandom_range(0, 39) == 0);
`endif
    endtask

    initial begin
        int pulses;
        rst = 1'b1; dma_go_i = 0; desc_valid_i = 0;
        desc_num_bytes_i = 0; desc_src_addr_i = 0; desc_dst_addr_i = 0;
        stream_rd_done_i = 0; stream_wr_done_i = 0; axi_pend_txn_i = 0;
        axi_err_valid_i = 0; axi_err_src_i = 0; axi_err_addr_i = 0;
        rd_err_valid_i = 0; rd_err_addr_i = 0; wr_err_valid_i = 0; wr_err_addr_i = 0;
`ifdef DMA_FSM_ABORT_EN
        abort_i = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        check_eq("rst_ready", desc_ready_o, 1);
        check_eq("rst_level", queue_level_o, 0);
        check_eq("rst_active", dma_active_o, 0);
        check_eq("rst_done", dma_done_o, 0);
        check_eq("rst_cnt", desc_done_cnt_o, 0);
        check_eq("rst_err", err_valid_o, 0);

        // Three descriptors, error priority and lock, delayed write completion, drain.
        set_desc(64, 32'h1000, 32'h2000); step();
        set_desc(128, 32'h1100, 32'h2100); step();
        set_desc(32, 32'h1200, 32'h2200); step();
        desc_valid_i = 0;
        check_eq("s1_level", queue_level_o, 3);
        dma_go_i = 1; step();
        check_eq("s1_active", dma_active_o, 1);
        check_eq("s1_head0", cur_num_bytes_o, 64);
        check_eq("s1_rdv0", stream_rd_valid_o, 1);
        axi_err_valid_i = 1; axi_err_src_i = 1; axi_err_addr_i = 32'h100;
        rd_err_valid_i = 1; rd_err_addr_i = 32'h200;
        stream_rd_done_i = 1; stream_wr_done_i = 1; step();
        axi_err_valid_i = 0; rd_err_valid_i = 0;
        wr_err_valid_i = 1; wr_err_addr_i = 32'h300;
        stream_rd_done_i = 0; stream_wr_done_i = 0;
        #1;
        check_eq("s1_head1", cur_num_bytes_o, 128);
        check_eq("s1_cnt1", desc_done_cnt_o, 1);
        check_eq("s1_err_addr", err_addr_o, 32'h100);
        check_eq("s1_err_src", err_src_o, 1);
        stream_rd_done_i = 1; step();
        stream_rd_done_i = 0; wr_err_valid_i = 0;
        #1;
        check_eq("s1_rd_low", stream_rd_valid_o, 0);
        check_eq("s1_wr_high", stream_wr_valid_o, 1);
        check_eq("s1_err_lock", err_addr_o, 32'h100);
        repeat (4) step();
        stream_wr_done_i = 1; step();
        stream_wr_done_i = 0;
        #1;
        check_eq("s1_head2", cur_num_bytes_o, 32);
        check_eq("s1_cnt2", desc_done_cnt_o, 2);
        stream_rd_done_i = 1; stream_wr_done_i = 1; step();
        stream_rd_done_i = 0; stream_wr_done_i = 0; axi_pend_txn_i = 1;
        #1;
        check_eq("s1_cnt3", desc_done_cnt_o, 3);
        check_eq("s1_drain", dma_active_o, 1);
        repeat (4) step();
        check_eq("s1_pend_hold", dma_done_o, 0);
        axi_pend_txn_i = 0; step();
        check_eq("s1_done", dma_done_o, 1);
        dma_go_i = 0; step();
        check_eq("s1_clear", clear_dma_o, 1);
        step();
        check_eq("s1_clear_pulse", clear_dma_o, 0);

        // Start with an empty FIFO.
        dma_go_i = 1; step();
        check_eq("e_done", dma_done_o, 1);
        check_eq("e_rdv", stream_rd_valid_o, 0);
        dma_go_i = 0; step();
        check_eq("e_clear", clear_dma_o, 1);
        step();
        check_eq("e_idle", dma_done_o | clear_dma_o, 0);

        // Zero-length descriptor between two 16-byte descriptors.
        set_desc(16, 32'h10, 32'h20); step();
        set_desc(0, 32'h30, 32'h40); step();
        set_desc(16, 32'h50, 32'h60); step();
        desc_valid_i = 0; dma_go_i = 1; step();
        run_until_done("z_timeout", 40, pulses);
        check_eq("z_cnt", desc_done_cnt_o, 3);
        check_eq("z_rd_pulses", pulses, 2);
        dma_go_i = 0; repeat (2) step();

        // Fill to capacity; an extra push is refused.
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_desc(32'(8 * (i + 1)), 32'(i), 32'(i + 100)); step();
        end
        desc_valid_i = 0;
        check_eq("f_ready", desc_ready_o, 0);
        check_eq("f_level", queue_level_o, DEPTH);
        dma_go_i = 1; step();
        run_until_done("f_timeout", 60, pulses);
        check_eq("f_cnt", desc_done_cnt_o, DEPTH);
        dma_go_i = 0; repeat (2) step();

`ifdef DMA_FSM_ABORT_EN
        for (int i = 0; i < 3; i++) begin
            set_desc(64, 32'(i), 32'(i)); step();
        end
        desc_valid_i = 0; dma_go_i = 1; step();
        abort_i = 1; step();
        abort_i = 0;
        #1;
        check_eq("a_level", queue_level_o, 0);
        check_eq("a_aborted", aborted_o, 1);
        check_eq("a_rdv", stream_rd_valid_o, 0);
        step();
        dma_go_i = 0; repeat (2) step();
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
